// File: rtl/lreport.sv
// Beacon report generator: buffers pass-through packets and inserts an 8-word LCM report between packets.
// Latency: 2 cycles from a word entering an empty FIFO (while IDLE) to it appearing on out_lr_data.
// Backpressure: none upstream; a packet is refused whole when fewer than MAX_PKT_WORDS entries are free.
//
// Ports: clk/rst (sync, active-high); in_lr_data* upstream 134-bit stream; in_local_mac_id,
// in_lcm_mac_id, in_report_period, beacon_update_master and the live config registers feed the
// report; out_lr_data* downstream stream; report_seq and drop_pkt_cnt are status counters.
// Optional macro LREPORT_CNT_EN: report word 5 carries drop and accepted-packet counters.

module lreport_fifo #(
  parameter int W     = 135,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_rdy && (count != '0);
  assign do_push = push_vld && (count != FULL);
  assign pop_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module lreport #(
  parameter logic [7:0] LMID          = 8'd13,
  parameter int         FIFO_DEPTH    = 32,
  parameter int         MAX_PKT_WORDS = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in_lr_data,
  input  logic         in_lr_data_wr,
  input  logic         in_lr_data_valid,
  input  logic         in_lr_data_valid_wr,
  input  logic [47:0]  in_local_mac_id,
  input  logic [47:0]  in_lcm_mac_id,
  input  logic [31:0]  in_report_period,
  input  logic         beacon_update_master,
  input  logic [31:0]  time_slot_period,
  input  logic         direction,
  input  logic [31:0]  token_bucket_para,
  input  logic [47:0]  direct_mac_addr,
  output logic [133:0] out_lr_data,
  output logic         out_lr_data_wr,
  output logic         out_lr_data_valid,
  output logic         out_lr_data_valid_wr,
  output logic [15:0]  report_seq,
  output logic [31:0]  drop_pkt_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] NEED_W  = CW'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {IDLE, PASS, RPT} state_t;
  state_t state;

  logic [CW-1:0] fifo_cnt;
  logic [134:0]  pop_dat;
  logic          is_head;
  logic          admit;
  logic          push_vld;
  logic          in_pkt;
  logic [31:0]   per_cnt;
  logic          bum_q;
  logic          pending;
  logic          period_hit;
  logic          trig;
  logic          rpt_start;
  logic [2:0]    rpt_idx;
  logic [133:0]  rpt_word;
  logic [47:0]   snap_dmac;
  logic          snap_dir;
  logic [31:0]   snap_tbp;
  logic [31:0]   snap_tsp;

  // Admission is decided once per packet on its head word; body words follow that decision.
  assign is_head  = in_lr_data_wr && (in_lr_data[133:132] == 2'b01);
  assign admit    = (DEPTH_W - fifo_cnt) >= NEED_W;
  assign push_vld = in_lr_data_wr && (is_head ? admit : in_pkt);

  lreport_fifo #(.W(135), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat ({in_lr_data_valid & in_lr_data_valid_wr, in_lr_data}),
    .pop_rdy  (state == PASS),
    .pop_dat  (pop_dat),
    .count    (fifo_cnt)
  );

`ifdef LREPORT_CNT_EN
  logic [31:0] acc_pkt_cnt;
  always_ff @(posedge clk) begin
    if (rst) acc_pkt_cnt <= '0;
    else if (is_head && admit) acc_pkt_cnt <= acc_pkt_cnt + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt       <= 1'b0;
      drop_pkt_cnt <= '0;
    end else if (is_head) begin
      in_pkt <= admit;
      if (!admit && drop_pkt_cnt != 32'hFFFF_FFFF) drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
    end else if (in_lr_data_wr && in_lr_data[133:132] == 2'b10) begin
      in_pkt <= 1'b0;
    end
  end

  // A counter left above a newly lowered period free-runs through 32'hFFFFFFFF back to 0.
  assign period_hit = (in_report_period != '0) && (per_cnt == in_report_period - 32'd1);
  assign trig       = period_hit || (beacon_update_master != bum_q);
  assign rpt_start  = (state == IDLE) && pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      bum_q   <= beacon_update_master;
      pending <= 1'b0;
    end else begin
      bum_q <= beacon_update_master;
      if (in_report_period != '0) per_cnt <= period_hit ? 32'd0 : per_cnt + 32'd1;
      // A trigger in the entry cycle re-arms pending rather than being absorbed.
      pending <= trig || (pending && !rpt_start);
    end
  end

  always_comb begin
    rpt_word = {2'b11, 132'd0};
    case (rpt_idx)
      3'd0: rpt_word = {2'b01, 4'h0, 1'b1, 7'd0, LMID, 112'd0};
      3'd2: rpt_word = {2'b11, 4'h0, in_lcm_mac_id, in_local_mac_id, 16'hFF01, 4'h0, 4'hE, 8'h00};
      3'd3: rpt_word = {2'b11, 4'h0, snap_dmac, snap_dir, 15'd0, snap_tbp, snap_tsp};
      3'd4: rpt_word = {2'b11, 116'd0, report_seq + 16'd1};
`ifdef LREPORT_CNT_EN
      3'd5: rpt_word = {2'b11, 68'd0, drop_pkt_cnt, acc_pkt_cnt};
`endif
      3'd7: rpt_word = {2'b10, 132'd0};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      rpt_idx              <= '0;
      report_seq           <= '0;
      out_lr_data          <= '0;
      out_lr_data_wr       <= 1'b0;
      out_lr_data_valid    <= 1'b0;
      out_lr_data_valid_wr <= 1'b0;
      snap_dmac            <= '0;
      snap_dir             <= 1'b0;
      snap_tbp             <= '0;
      snap_tsp             <= '0;
    end else begin
      out_lr_data_wr       <= 1'b0;
      out_lr_data_valid    <= 1'b0;
      out_lr_data_valid_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            state     <= RPT;
            rpt_idx   <= '0;
            snap_dmac <= direct_mac_addr;
            snap_dir  <= direction;
            snap_tbp  <= token_bucket_para;
            snap_tsp  <= time_slot_period;
          end else if (fifo_cnt != '0) begin
            state <= PASS;
          end
        end
        PASS: begin
          // Empty FIFO mid-packet simply stalls with wr low.
          if (fifo_cnt != '0) begin
            out_lr_data    <= pop_dat[133:0];
            out_lr_data_wr <= 1'b1;
            if (pop_dat[133:132] == 2'b10) begin
              out_lr_data_valid    <= pop_dat[134];
              out_lr_data_valid_wr <= 1'b1;
              state                <= IDLE;
            end
          end
        end
        RPT: begin
          out_lr_data    <= rpt_word;
          out_lr_data_wr <= 1'b1;
          rpt_idx        <= rpt_idx + 3'd1;
          if (rpt_idx == 3'd7) begin
            out_lr_data_valid    <= 1'b1;
            out_lr_data_valid_wr <= 1'b1;
            report_seq           <= report_seq + 16'd1;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lreport.sv
`timescale 1ns/1ps
module tb_lreport;
  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] in_lr_data;
  logic         in_lr_data_wr, in_lr_data_valid, in_lr_data_valid_wr;
  logic [47:0]  in_local_mac_id, in_lcm_mac_id;
  logic [31:0]  in_report_period;
  logic         beacon_update_master;
  logic [31:0]  time_slot_period;
  logic         direction;
  logic [31:0]  token_bucket_para;
  logic [47:0]  direct_mac_addr;
  logic [133:0] out_lr_data;
  logic         out_lr_data_wr, out_lr_data_valid, out_lr_data_valid_wr;
  logic [15:0]  report_seq;
  logic [31:0]  drop_pkt_cnt;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  typedef struct { logic [133:0] d; logic v; logic vwr; int unsigned c; } cap_t;
  typedef struct { logic [133:0] d; logic v; } word_t;
  cap_t  cap[$];
  cap_t  pkt_q[$];
  cap_t  rpt_q[$];
  word_t exp_q[$];
  int unsigned in_c[$];
  logic [31:0] m_drop;
  logic [31:0] m_acc;
`ifdef LREPORT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  lreport dut (
    .clk(clk), .rst(rst),
    .in_lr_data(in_lr_data), .in_lr_data_wr(in_lr_data_wr),
    .in_lr_data_valid(in_lr_data_valid), .in_lr_data_valid_wr(in_lr_data_valid_wr),
    .in_local_mac_id(in_local_mac_id), .in_lcm_mac_id(in_lcm_mac_id),
    .in_report_period(in_report_period), .beacon_update_master(beacon_update_master),
    .time_slot_period(time_slot_period), .direction(direction),
    .token_bucket_para(token_bucket_para), .direct_mac_addr(direct_mac_addr),
    .out_lr_data(out_lr_data), .out_lr_data_wr(out_lr_data_wr),
    .out_lr_data_valid(out_lr_data_valid), .out_lr_data_valid_wr(out_lr_data_valid_wr),
    .report_seq(report_seq), .drop_pkt_cnt(drop_pkt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive capture of every output word, stamped with the edge that produced it.
  always begin
    cap_t e;
    @(posedge clk);
    #1;
    if (!rst && out_lr_data_wr) begin
      e.d = out_lr_data; e.v = out_lr_data_valid; e.vwr = out_lr_data_valid_wr; e.c = cyc;
      cap.push_back(e);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected report word j built field by field from the message layout.
  function automatic logic [133:0] exp_rpt(input int j, input logic [15:0] seq);
    logic [133:0] w;
    w = '0;
    w[133:132] = (j == 0) ? 2'b01 : ((j == 7) ? 2'b10 : 2'b11);
    if (j == 0) begin w[127] = 1'b1; w[119:112] = 8'd13; end
    if (j == 2) begin
      w[127:80] = in_lcm_mac_id; w[79:32] = in_local_mac_id; w[31:16] = 16'hFF01; w[11:8] = 4'hE;
    end
    if (j == 3) begin
      w[127:80] = direct_mac_addr; w[79] = direction; w[63:32] = token_bucket_para; w[31:0] = time_slot_period;
    end
    if (j == 4) w[15:0] = seq;
    if (j == 5 && CNT_EN) begin w[63:32] = m_drop; w[31:0] = m_acc; end
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_lr_data = '0; in_lr_data_wr = 1'b0; in_lr_data_valid = 1'b0; in_lr_data_valid_wr = 1'b0;
    in_report_period = '0;
    tick(3);
    rst = 1'b0;
    cap.delete(); exp_q.delete(); in_c.delete();
    m_drop = '0; m_acc = '0;
  endtask

  // Sends an n-word packet back to back; acc says whether the model expects it admitted.
  task automatic send_pkt(input int n, input logic tv, input int tog_at, input bit acc);
    logic [159:0] r;
    logic [133:0] w;
    word_t e;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      w = r[133:0];
      w[133:132] = (i == 0) ? 2'b01 : ((i == n-1) ? 2'b10 : 2'b11);
      if (i == 0) w[127] = 1'b0;
      if (i == tog_at) beacon_update_master = ~beacon_update_master;
      in_lr_data = w; in_lr_data_wr = 1'b1;
      in_lr_data_valid = (i == n-1) ? tv : 1'b0;
      in_lr_data_valid_wr = (i == n-1);
      tick(1);
      in_c.push_back(cyc);
      e.d = w; e.v = (i == n-1) ? tv : 1'b0;
      if (acc) exp_q.push_back(e);
      in_lr_data_wr = 1'b0; in_lr_data_valid = 1'b0; in_lr_data_valid_wr = 1'b0;
    end
    if (acc) m_acc = m_acc + 1; else m_drop = m_drop + 1;
  endtask

  task automatic split();
    bit in_rpt;
    in_rpt = 1'b0;
    pkt_q.delete(); rpt_q.delete();
    foreach (cap[i]) begin
      if (cap[i].d[133:132] == 2'b01) in_rpt = cap[i].d[127];
      if (in_rpt) rpt_q.push_back(cap[i]); else pkt_q.push_back(cap[i]);
    end
  endtask

  task automatic wait_cap(input int n, input int budget, input string nm);
    int t;
    t = 0;
    while (cap.size() < n && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (cap.size() < n) begin
      failures++; $display("FAIL %s timeout: captured %0d words, need %0d", nm, cap.size(), n);
    end
  endtask

  task automatic test_reset();
    beacon_update_master = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (out_lr_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", out_lr_data); end
    checks++; if (out_lr_data_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b want 0", out_lr_data_wr); end
    checks++; if (out_lr_data_valid !== 1'b0 || out_lr_data_valid_wr !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b%b want 00", out_lr_data_valid, out_lr_data_valid_wr); end
    checks++; if (report_seq !== 16'd0) begin failures++; $display("FAIL reset_seq: got %0d want 0", report_seq); end
    checks++; if (drop_pkt_cnt !== 32'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_pkt_cnt); end
    tick(20);
    checks++; if (cap.size() != 0) begin failures++; $display("FAIL reset_no_report: got %0d words want 0", cap.size()); end
  endtask

  task automatic test_passthru();
    do_reset();
    send_pkt(4, 1'b1, -1, 1'b1);
    tick(10);
    checks++; if (cap.size() != 4) begin failures++; $display("FAIL pass4_count: got %0d want 4", cap.size()); end
    for (int i = 0; i < cap.size() && i < 4; i++) begin
      checks++; if (cap[i].d !== exp_q[i].d) begin failures++; $display("FAIL pass4_data[%0d]: got %h want %h", i, cap[i].d, exp_q[i].d); end
      checks++; if (cap[i].c != in_c[i] + 2) begin failures++; $display("FAIL pass4_latency[%0d]: got cycle %0d want %0d", i, cap[i].c, in_c[i] + 2); end
      checks++; if (cap[i].vwr !== (i == 3) || cap[i].v !== (i == 3)) begin
        failures++; $display("FAIL pass4_valid[%0d]: got v=%b vwr=%b want %b", i, cap[i].v, cap[i].vwr, i == 3); end
    end
    cap.delete(); exp_q.delete();
    for (int p = 0; p < 8; p++) begin
      send_pkt($urandom_range(2, 10), 1'($urandom_range(0, 1)), -1, 1'b1);
      tick($urandom_range(1, 4));
    end
    tick(20);
    checks++; if (cap.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap[i].d !== exp_q[i].d || cap[i].v !== exp_q[i].v || cap[i].vwr !== (exp_q[i].d[133:132] == 2'b10)) begin
        failures++; $display("FAIL rand_word[%0d]: got %h v=%b want %h v=%b", i, cap[i].d, cap[i].v, exp_q[i].d, exp_q[i].v);
      end
    end
  endtask

  task automatic test_period();
    do_reset();
    time_slot_period = 32'd7; direction = 1'b1; token_bucket_para = 32'd10;
    direct_mac_addr = 48'h0011_2233_4455;
    in_report_period = 32'd100;
    for (int k = 1; k <= 3; k++) begin
      wait_cap(8 * k, 400, "period_wait");
      checks++; if (report_seq !== 16'(k)) begin failures++; $display("FAIL period_seq: got %0d want %0d", report_seq, k); end
    end
    in_report_period = '0;
    split();
    checks++; if (rpt_q.size() != 24) begin failures++; $display("FAIL period_words: got %0d want 24", rpt_q.size()); end
    for (int i = 0; i < rpt_q.size() && i < 24; i++) begin
      checks++;
      if (rpt_q[i].d !== exp_rpt(i % 8, 16'(i / 8 + 1)) || rpt_q[i].vwr !== (i % 8 == 7) || rpt_q[i].c != rpt_q[i - i % 8].c + (i % 8)) begin
        failures++; $display("FAIL period_word[%0d]: got %h want %h", i, rpt_q[i].d, exp_rpt(i % 8, 16'(i / 8 + 1)));
      end
    end
    if (rpt_q.size() >= 24) begin
      checks++; if (rpt_q[8].c - rpt_q[0].c != 100 || rpt_q[16].c - rpt_q[8].c != 100) begin
        failures++; $display("FAIL period_interval: got %0d,%0d want 100", rpt_q[8].c - rpt_q[0].c, rpt_q[16].c - rpt_q[8].c); end
    end
  endtask

  task automatic test_toggle_mid_pkt();
    do_reset();
    direct_mac_addr = {$urandom(), 16'($urandom())}; token_bucket_para = $urandom();
    time_slot_period = $urandom(); direction = 1'($urandom_range(0, 1));
    send_pkt(20, 1'b1, 5, 1'b1);
    tick(40);
    split();
    checks++; if (cap.size() != 28 || pkt_q.size() != 20) begin
      failures++; $display("FAIL mid_count: got %0d total %0d pkt want 28 20", cap.size(), pkt_q.size()); end
    for (int i = 0; i < pkt_q.size() && i < 20; i++) begin
      checks++; if (pkt_q[i].d !== exp_q[i].d || pkt_q[i].c != pkt_q[0].c + i) begin
        failures++; $display("FAIL mid_pkt[%0d]: got %h want %h", i, pkt_q[i].d, exp_q[i].d); end
    end
    for (int j = 0; j < rpt_q.size() && j < 8; j++) begin
      checks++; if (rpt_q[j].d !== exp_rpt(j, 16'd1)) begin
        failures++; $display("FAIL mid_rpt[%0d]: got %h want %h", j, rpt_q[j].d, exp_rpt(j, 16'd1)); end
    end
    if (cap.size() == 28) begin
      checks++; if (cap[20].c != cap[19].c + 2) begin
        failures++; $display("FAIL mid_gap: report at %0d want %0d", cap[20].c, cap[19].c + 2); end
    end
    checks++; if (report_seq !== 16'd1) begin failures++; $display("FAIL mid_seq: got %0d want 1", report_seq); end
  endtask

  task automatic test_simultaneous();
    int unsigned h;
    int t;
    do_reset();
    in_report_period = 32'd30;
    wait_cap(1, 80, "simul_first");
    h = (cap.size() > 0) ? cap[0].c - 2 : cyc;
    t = 0;
    while (cyc < h + 29 && t < 100) begin tick(1); t++; end
    beacon_update_master = ~beacon_update_master;
    wait_cap(9, 60, "simul_second");
    if (cap.size() >= 9) begin
      checks++; if (cap[8].c != h + 32) begin failures++; $display("FAIL simul_time: got %0d want %0d", cap[8].c, h + 32); end
    end
    in_report_period = '0;
    tick(40);
    checks++; if (cap.size() != 16) begin failures++; $display("FAIL simul_words: got %0d want 16", cap.size()); end
    checks++; if (report_seq !== 16'd2) begin failures++; $display("FAIL simul_seq: got %0d want 2", report_seq); end
  endtask

  task automatic test_drop();
    do_reset();
    fork
      begin
        for (int i = 0; i < 22; i++) begin beacon_update_master = ~beacon_update_master; tick(4); end
      end
      begin
        tick(4);
        send_pkt(22, 1'b1, -1, 1'b1);
        send_pkt(12, 1'b0, -1, 1'b0);
      end
    join
    tick(60);
    checks++; if (drop_pkt_cnt !== 32'd1) begin failures++; $display("FAIL drop_cnt: got %0d want 1", drop_pkt_cnt); end
    send_pkt(4, 1'b1, -1, 1'b1);
    tick(40);
    split();
    checks++; if (pkt_q.size() != 26) begin failures++; $display("FAIL drop_pkt_words: got %0d want 26", pkt_q.size()); end
    for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) begin
      checks++; if (pkt_q[i].d !== exp_q[i].d) begin
        failures++; $display("FAIL drop_pkt[%0d]: got %h want %h", i, pkt_q[i].d, exp_q[i].d); end
    end
    checks++; if (rpt_q.size() % 8 != 0 || rpt_q.size() < 16 || report_seq !== 16'(rpt_q.size() / 8)) begin
      failures++; $display("FAIL drop_reports: got %0d words seq %0d want multiple of 8", rpt_q.size(), report_seq); end
    for (int i = 0; i < rpt_q.size(); i++) begin
      if (i % 8 != 5 || !CNT_EN) begin
        checks++;
        if (rpt_q[i].d !== exp_rpt(i % 8, 16'(i / 8 + 1)) || rpt_q[i].c != rpt_q[i - i % 8].c + (i % 8)) begin
          failures++; $display("FAIL drop_rpt[%0d]: got %h want %h", i, rpt_q[i].d, exp_rpt(i % 8, 16'(i / 8 + 1)));
        end
      end
    end
  endtask

  task automatic test_reset_in_rpt();
    do_reset();
    beacon_update_master = ~beacon_update_master;
    wait_cap(8, 40, "rst_first");
    checks++; if (report_seq !== 16'd1) begin failures++; $display("FAIL rst_seq_pre: got %0d want 1", report_seq); end
    beacon_update_master = ~beacon_update_master;
    wait_cap(13, 40, "rst_w4");
    if (cap.size() >= 13) begin
      checks++; if (cap[12].d !== exp_rpt(4, 16'd2)) begin
        failures++; $display("FAIL rst_w4: got %h want %h", cap[12].d, exp_rpt(4, 16'd2)); end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_lr_data !== '0 || out_lr_data_wr !== 1'b0 || out_lr_data_valid !== 1'b0 || out_lr_data_valid_wr !== 1'b0) begin
      failures++; $display("FAIL rst_outputs: got wr=%b v=%b vwr=%b data=%h want all 0", out_lr_data_wr, out_lr_data_valid, out_lr_data_valid_wr, out_lr_data); end
    checks++; if (report_seq !== 16'd0) begin failures++; $display("FAIL rst_seq: got %0d want 0", report_seq); end
    @(posedge clk); #1;
    rst = 1'b0;
    cap.delete();
    beacon_update_master = ~beacon_update_master;
    wait_cap(8, 40, "rst_after");
    for (int j = 0; j < cap.size() && j < 8; j++) begin
      checks++; if (cap[j].d !== exp_rpt(j, 16'd1)) begin
        failures++; $display("FAIL rst_restart[%0d]: got %h want %h", j, cap[j].d, exp_rpt(j, 16'd1)); end
    end
    checks++; if (report_seq !== 16'd1) begin failures++; $display("FAIL rst_seq_post: got %0d want 1", report_seq); end
  endtask

  initial begin
    rst = 1'b1;
    in_lr_data = '0; in_lr_data_wr = 1'b0; in_lr_data_valid = 1'b0; in_lr_data_valid_wr = 1'b0;
    in_report_period = '0; beacon_update_master = 1'b0;
    in_local_mac_id = 48'hA1B2_C3D4_E5F6; in_lcm_mac_id = 48'h0102_0304_0506;
    time_slot_period = '0; direction = 1'b0; token_bucket_para = '0; direct_mac_addr = '0;
    m_drop = '0; m_acc = '0;
    test_reset();
    test_passthru();
    test_period();
    test_toggle_mid_pkt();
    test_simultaneous();
    test_drop();
    test_reset_in_rpt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lreport.md
Name: lreport

Overview:
- Generates the beacon report message that the LCM (local control module) consumes; it is the transmit-side counterpart of the beacon update path.
- Sits on the 134-bit packet stream feeding the switch fabric.
- Buffers pass-through packets, periodically or on demand builds an 8-word report packet from the live configuration registers, and inserts it between packets.

Parameters:
- LMID, 8'd13, module ID placed in report metadata word0[119:112].
- FIFO_DEPTH, 32, pass-through FIFO depth in 134-bit words plus 1 valid-bit (power of 2).
- MAX_PKT_WORDS, 24, free entries required to admit a packet.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_lr_data  in  134  upstream packet word; [133:132] 01 head / 11 middle / 10 tail.
- in_lr_data_wr  in  1  word strobe.
- in_lr_data_valid  in  1  packet-valid flag.
- in_lr_data_valid_wr  in  1  valid strobe; asserted with the tail word.
- in_local_mac_id  in  48  this node's MAC.
- in_lcm_mac_id  in  48  LCM MAC, used as report destination.
- in_report_period  in  32  report interval in clk cycles; 0 disables periodic reports.
- beacon_update_master  in  1  toggles on each applied update; any edge requests a report.
- time_slot_period  in  32  live register.
- direction  in  1  live register.
- token_bucket_para  in  32  live register.
- direct_mac_addr  in  48  live register.
- out_lr_data  out  134  output word.
- out_lr_data_wr  out  1  output strobe.
- out_lr_data_valid  out  1  output valid flag.
- out_lr_data_valid_wr  out  1  output valid strobe.
- report_seq  out  16  sequence number of the last emitted report.
- drop_pkt_cnt  out  32  packets refused at admission.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; state IDLE.
  - Period counter 0; pending 0; edge-detect register loaded with beacon_update_master.
  - Reset mid-packet truncates output immediately; no tail is emitted.
- Admission, evaluated on every head word:
  - Accept if FIFO free entries >= MAX_PKT_WORDS. All words up to and including the tail are then written, each with its valid bit.
  - Otherwise discard the whole packet and increment drop_pkt_cnt (saturating at 32'hFFFFFFFF).
  - Words that arrive outside an accepted packet are ignored.
- Triggers:
  - Period counter increments each cycle while in_report_period != 0.
  - When the counter reaches in_report_period-1, it wraps to 0 and sets pending.
  - Any toggle of beacon_update_master (registered edge detect) sets pending.
  - Simultaneous triggers, or triggers while pending is already set, collapse into one report.
  - Changing in_report_period does not reset the counter. If the counter is already >= the new value, it runs to 32'hFFFFFFFF and wraps.
- State machine:
  - IDLE:
    - If pending, go to RPT. A report has priority over a buffered packet at a packet boundary.
    - Else if the FIFO is non-empty, go to PASS.
  - PASS:
    - Pop one word per cycle and drive it with wr=1.
    - valid_wr=1 and valid=stored bit only on the tail word.
    - After the tail, go to IDLE.
    - An underrun (FIFO empty mid-packet) stalls output with wr=0 and stays in PASS.
  - RPT: emit 8 words on consecutive cycles; wr=1 on each; then go to IDLE.
    - w0 head 01: [127]=1 (locally generated), [119:112]=LMID.
    - w1 middle: 0.
    - w2: [127:80]=in_lcm_mac_id, [79:32]=in_local_mac_id, [31:16]=16'hFF01, [11:8]=4'hE (report type).
    - w3: [127:80]=direct_mac_addr, [79]=direction, [63:32]=token_bucket_para, [31:0]=time_slot_period. All four are sampled together in the RPT entry cycle.
    - w4: [15:0]=seq.
    - w5–w6: 0.
    - w7 tail 10 with valid=1 and valid_wr=1.
  - report_seq increments (16-bit wrap) on w7.
  - Pending clears on RPT entry. A trigger that arrives during RPT sets pending again.
  - [131:128] is 4'h0 on all report words.
- Latency: a word written into an empty FIFO while in IDLE appears on the output 2 cycles later.

Optional Feature:
- Macro: LREPORT_CNT_EN.
- When defined, w5 carries [63:32]=drop_pkt_cnt and [31:0]=count of accepted packets, 32-bit wrapping, reset 0.
- When undefined, w5 is 0 and the accepted-packet counter is not built.

Test Plan:
- Single 4-word packet in, period 0, no toggle -> identical 4 words out, each 2 cycles after input; valid_wr only on the tail.
- Period 100, registers tsp=7, dir=1, tb=10, dmac=48'h0011_2233_4455 -> report every 100 cycles; w2[11:8]=E; w3 fields match; report_seq=1, 2, 3….
- Toggle beacon_update_master while a 20-word packet is streaming -> packet completes intact, then the report follows with no interleaving.
- Period trigger and toggle on the same cycle -> exactly one report.
- FIFO preloaded to 10 free entries, 12-word packet arrives -> packet dropped entirely; drop_pkt_cnt=1; the next packet, arriving after the drain, passes.
- Assert rst during RPT w4 -> the next cycle has all outputs 0; after reset release, report_seq=0 and the next report restarts at w0.
